paddle_ctrl: RTL and testbench

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/paddle_ctrl_if.sv | 25 ++
 rtl/paddle_ctrl.sv | 147 ++++++++++++++
 tb/tb_paddle_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/paddle_ctrl_if.sv
// Game-core side signal bundle for paddle_ctrl: frame timing, player controls and paddle positions.
// The controller sits on the slave modport; the game core or bench drives the master modport.
interface paddle_ctrl_if;
   logic       vblank;
   logic       p1_up;
   logic       p1_down;
   logic       p2_up;
   logic       p2_down;
   logic       analog_mode;
   logic [7:0] p1_analog;
   logic [7:0] p2_analog;
   logic [7:0] paddle1_vpos;
   logic [7:0] paddle2_vpos;
   logic       frame_tick;

   modport master (
      output vblank, p1_up, p1_down, p2_up, p2_down, analog_mode, p1_analog, p2_analog,
      input  paddle1_vpos, paddle2_vpos, frame_tick
   );

   modport slave (
      input  vblank, p1_up, p1_down, p2_up, p2_down, analog_mode, p1_analog, p2_analog,
      output paddle1_vpos, paddle2_vpos, frame_tick
   );
endinterface

// File: rtl/paddle_ctrl.sv
// Two-player paddle position controller, updated once per vblank with accelerating digital moves.
// Define PADDLE_ANALOG_EN to honour analog_mode; otherwise the analog inputs are ignored.
module paddle_ctrl #(
   parameter logic [7:0] PAD_MIN      = 8'd0,
   parameter logic [7:0] PAD_MAX      = 8'd224,
   parameter logic [7:0] PAD_INIT     = 8'd112,
   parameter int         ACCEL_FRAMES = 8
) (
   input logic          mclk,
   input logic          reset,
   paddle_ctrl_if.slave bus
);

   localparam logic [7:0] ACCEL_W = 8'(ACCEL_FRAMES);

   typedef struct packed {
      logic [7:0] pos;
      logic [2:0] step;
      logic [7:0] hold;
      logic       dir;
   } player_t;

   localparam player_t PLAYER_RESET = '{pos: PAD_INIT, step: 3'd1, hold: 8'd0, dir: 1'b0};

   logic       sync1_r;
   logic       sync2_r;
   logic       sync3_r;
   logic [1:0] fill_r;
   logic       armed_r;
   logic       frame_event_s;
   logic       tick_r;
   logic       amode_s;
   player_t    p1_r;
   player_t    p2_r;
   player_t    p1_next_s;
   player_t    p2_next_s;

   function automatic logic [7:0] clamp_pos(input logic signed [8:0] value);
      logic [7:0] result;
      if (value < $signed({1'b0, PAD_MIN})) begin
         result = PAD_MIN;
      end else if (value > $signed({1'b0, PAD_MAX})) begin
         result = PAD_MAX;
      end else begin
         result = value[7:0];
      end
      return result;
   endfunction

   // dir = 1 means moving up; a change of direction restarts acceleration from step 1
   function automatic player_t player_next(input player_t cur, input logic up, input logic down,
                                           input logic amode, input logic [7:0] analog);
      player_t           nxt;
      logic [2:0]        step_use;
      logic [7:0]        hold_use;
      logic signed [8:0] delta;
      nxt      = cur;
      step_use = cur.step;
      hold_use = cur.hold;
      delta    = 9'sd0;
      if (amode) begin
         nxt.pos  = clamp_pos($signed({1'b0, analog}));
         nxt.step = 3'd1;
         nxt.hold = 8'd0;
      end else if (up != down) begin
         if (up != cur.dir) begin
            step_use = 3'd1;
            hold_use = 8'd0;
         end else begin
            step_use = cur.step;
            hold_use = cur.hold;
         end
         delta   = up ? -$signed({6'd0, step_use}) : $signed({6'd0, step_use});
         nxt.pos = clamp_pos($signed({1'b0, cur.pos}) + delta);
         nxt.dir = up;
         if (hold_use + 8'd1 >= ACCEL_W) begin
            nxt.hold = 8'd0;
            nxt.step = (step_use == 3'd4) ? 3'd4 : step_use + 3'd1;
         end else begin
            nxt.hold = hold_use + 8'd1;
            nxt.step = step_use;
         end
      end else begin
         nxt.step = 3'd1;
         nxt.hold = 8'd0;
      end
      return nxt;
   endfunction

`ifdef PADDLE_ANALOG_EN
   assign amode_s = bus.analog_mode;
`else
   logic unused_analog_s;
   assign unused_analog_s = ^{bus.analog_mode, bus.p1_analog, bus.p2_analog};
   assign amode_s         = 1'b0;
`endif

   // vblank synchronizer and edge detector; an edge only counts once vblank was seen low after reset
   always_ff @(posedge mclk) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         sync3_r <= 1'b0;
         fill_r  <= 2'b00;
         armed_r <= 1'b0;
      end else begin
         sync1_r <= bus.vblank;
         sync2_r <= sync1_r;
         sync3_r <= sync2_r;
         fill_r  <= {fill_r[0], 1'b1};
         armed_r <= armed_r | (fill_r[1] & ~sync2_r);
      end
   end

   assign frame_event_s = sync2_r & ~sync3_r & armed_r;

   // Next paddle state for both players, evaluated every cycle and committed on a frame event
   always_comb begin
      p1_next_s = p1_r;
      p2_next_s = p2_r;
      p1_next_s = player_next(p1_r, bus.p1_up, bus.p1_down, amode_s, bus.p1_analog);
      p2_next_s = player_next(p2_r, bus.p2_up, bus.p2_down, amode_s, bus.p2_analog);
   end

   // Frame tick and paddle state registers
   always_ff @(posedge mclk) begin
      if (reset) begin
         tick_r <= 1'b0;
         p1_r   <= PLAYER_RESET;
         p2_r   <= PLAYER_RESET;
      end else begin
         tick_r <= frame_event_s;
         if (frame_event_s) begin
            p1_r <= p1_next_s;
            p2_r <= p2_next_s;
         end else begin
            p1_r <= p1_r;
            p2_r <= p2_r;
         end
      end
   end

   assign bus.frame_tick   = tick_r;
   assign bus.paddle1_vpos = p1_r.pos;
   assign bus.paddle2_vpos = p2_r.pos;

endmodule

// File: tb/tb_paddle_ctrl.sv
// Scoreboard bench for paddle_ctrl: stimulus pushes model-predicted positions per vblank,
// a monitor pops them on every frame_tick and also checks tick width and hold between ticks.
module tb_paddle_ctrl;

   localparam int ACCEL = 8;
   localparam int PMIN  = 0;
   localparam int PMAX  = 224;
   localparam int PINIT = 112;
`ifdef PADDLE_ANALOG_EN
   localparam bit ANALOG_EN = 1'b1;
`else
   localparam bit ANALOG_EN = 1'b0;
`endif

   typedef struct {
      int p1;
      int p2;
   } exp_t;

   logic mclk = 1'b0;
   logic reset = 1'b0;
   paddle_ctrl_if bus ();

   paddle_ctrl #(
      .PAD_MIN(8'd0), .PAD_MAX(8'd224), .PAD_INIT(8'd112), .ACCEL_FRAMES(8)
   ) dut (
      .mclk (mclk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 mclk = ~mclk;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   int   m_pos1, m_run1, m_dir1;
   int   m_pos2, m_run2, m_dir2;

   function automatic int clampi(input int v);
      if (v < PMIN) return PMIN;
      if (v > PMAX) return PMAX;
      return v;
   endfunction

   // Reference: run = consecutive ticks held in one direction; step = min(1 + (run-1)/ACCEL, 4)
   task automatic model_player(input bit up, input bit dn, input bit am, input int a,
                               inout int pos, inout int run, inout int dir);
      int d;
      int step;
      if (am && ANALOG_EN) begin
         pos = clampi(a);
         run = 0;
      end else if (up != dn) begin
         d = up ? -1 : 1;
         if (d != dir) run = 0;
         run++;
         step = 1 + (run - 1) / ACCEL;
         if (step > 4) step = 4;
         pos = clampi(pos + d * step);
         dir = d;
      end else begin
         run = 0;
      end
   endtask

   task automatic model_reset();
      m_pos1 = PINIT; m_run1 = 0; m_dir1 = 0;
      m_pos2 = PINIT; m_run2 = 0; m_dir2 = 0;
   endtask

   task automatic check_pos(input string name, input int want1, input int want2);
      checks++;
      if (int'(bus.paddle1_vpos) != want1 || int'(bus.paddle2_vpos) != want2 || bus.frame_tick !== 1'b0) begin
         errors++;
         $display("FAIL %s: got p1=%0d p2=%0d tick=%b, want p1=%0d p2=%0d tick=0",
                  name, bus.paddle1_vpos, bus.paddle2_vpos, bus.frame_tick, want1, want2);
      end
   endtask

   task automatic do_reset();
      bus.vblank = 1'b0;
      bus.p1_up = 1'b0; bus.p1_down = 1'b0; bus.p2_up = 1'b0; bus.p2_down = 1'b0;
      bus.analog_mode = 1'b0; bus.p1_analog = 8'd0; bus.p2_analog = 8'd0;
      reset = 1'b1;
      repeat (3) @(negedge mclk);
      reset = 1'b0;
      model_reset();
      repeat (4) @(negedge mclk);
      check_pos("reset_state", PINIT, PINIT);
   endtask

   task automatic frame(input bit u1, input bit d1, input bit u2, input bit d2,
                        input bit am, input logic [7:0] a1, input logic [7:0] a2);
      exp_t e;
      bus.p1_up = u1; bus.p1_down = d1; bus.p2_up = u2; bus.p2_down = d2;
      bus.analog_mode = am; bus.p1_analog = a1; bus.p2_analog = a2;
      model_player(u1, d1, am, int'(a1), m_pos1, m_run1, m_dir1);
      model_player(u2, d2, am, int'(a2), m_pos2, m_run2, m_dir2);
      e.p1 = m_pos1;
      e.p2 = m_pos2;
      exp_q.push_back(e);
      bus.vblank = 1'b1;
      repeat (4) @(negedge mclk);
      bus.vblank = 1'b0;
      repeat (4) @(negedge mclk);
   endtask

   // Monitor: pop one expectation per tick, flag double-wide ticks and moves between ticks
   initial begin
      bit   tick_prev = 1'b0;
      logic [7:0] prev1 = 8'd0;
      logic [7:0] prev2 = 8'd0;
      exp_t e;
      forever begin
         @(negedge mclk);
         if (mon_en && !reset) begin
            if (bus.frame_tick) begin
               checks++;
               if (tick_prev) begin
                  errors++;
                  $display("FAIL tick_width: frame_tick high 2 cycles in a row, want 1-cycle pulse");
               end
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_tick: got tick p1=%0d p2=%0d, want no tick",
                           bus.paddle1_vpos, bus.paddle2_vpos);
               end else begin
                  e = exp_q.pop_front();
                  if (int'(bus.paddle1_vpos) != e.p1 || int'(bus.paddle2_vpos) != e.p2) begin
                     errors++;
                     $display("FAIL tick_pos: got p1=%0d p2=%0d, want p1=%0d p2=%0d",
                              bus.paddle1_vpos, bus.paddle2_vpos, e.p1, e.p2);
                  end
               end
            end else begin
               checks++;
               if (bus.paddle1_vpos != prev1 || bus.paddle2_vpos != prev2) begin
                  errors++;
                  $display("FAIL hold: got p1=%0d p2=%0d without tick, want p1=%0d p2=%0d",
                           bus.paddle1_vpos, bus.paddle2_vpos, prev1, prev2);
               end
            end
         end
         tick_prev = bus.frame_tick && !reset;
         prev1     = bus.paddle1_vpos;
         prev2     = bus.paddle2_vpos;
      end
   end

   initial begin
      model_reset();
      do_reset();
      mon_en = 1'b1;

      // idle frames: positions stay at init, one tick each
      repeat (3) frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

      // p1 down for 10 frames: eight steps of 1 then steps of 2
      repeat (10) frame(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

      // p2 up long enough to hit the top limit and stay there
      repeat (60) frame(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

      // both p1 buttons held, then a single up frame moves by exactly 1
      repeat (5) frame(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
      frame(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

      // analog frame with one out-of-range value, then back to digital
      frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd250, 8'd40);
      frame(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);

      // reset two cycles after a vblank rise swallows that frame
      bus.vblank = 1'b1;
      @(negedge mclk);
      @(negedge mclk);
      reset = 1'b1;
      repeat (2) @(negedge mclk);
      reset = 1'b0;
      model_reset();
      repeat (4) @(negedge mclk);
      check_pos("reset_mid_frame", PINIT, PINIT);
      bus.vblank = 1'b0;
      repeat (4) @(negedge mclk);
      frame(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0);

      // randomized frames with occasional resets
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 39) == 0) begin
            do_reset();
         end else begin
            frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
         end
      end

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge mclk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_ticks: got %0d expected ticks still pending, want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
